// File: rtl/ntt_butterfly.sv
// Pipelined radix-2 NTT butterfly (Q = 3329) for the forward (Cooley-Tukey) and inverse
// (Gentleman-Sande) transforms, with an internal 3-stage Barrett modular multiplier.

module modular_mul #(
  parameter int Q = 3329
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] p
);

  // floor(2^24 / Q): the quotient estimate undershoots by at most one, so one subtract finishes
  localparam int unsigned BARRETT_M = (32'd1 << 24) / Q;
  localparam logic [12:0] QM = 13'(Q);

  logic [23:0] prod_s1;
  logic [23:0] prod_s2;
  logic [11:0] q_s2;
  logic [11:0] q_est;
  logic [12:0] rem;

  assign q_est = 12'(({12'd0, prod_s1} * 36'(BARRETT_M)) >> 24);
  assign rem   = 13'(prod_s2 - {12'd0, q_s2} * 24'(Q));

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_s1 <= '0;
      prod_s2 <= '0;
      q_s2    <= '0;
      p       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples
      // the previous cycle's values regardless of statement order.
      prod_s1 <= {12'd0, a} * {12'd0, b};
      prod_s2 <= prod_s1;
      q_s2    <= q_est;
      p       <= (rem >= QM) ? 12'(rem - QM) : rem[11:0];
    end
  end

endmodule

module ntt_butterfly #(
  parameter int Q       = 3329,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [11:0]      u,
  input  logic [11:0]      v,
  input  logic [11:0]      w,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  output logic [11:0]      out0,
  output logic [11:0]      out1,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [12:0] QM = 13'(Q);

  function automatic logic [11:0] modadd(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= QM) sum = sum - QM;
    return sum[11:0];
  endfunction

  function automatic logic [11:0] modsub(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] diff;
    if (a >= b) diff = {1'b0, a} - {1'b0, b};
    else        diff = {1'b0, a} + QM - {1'b0, b};
    return diff[11:0];
  endfunction

  // Stage P
  logic             valid_p;
  logic             mode_p;
  logic [TAG_W-1:0] tag_p;
  logic [11:0]      u_p;
  logic [11:0]      v_p;
  logic [11:0]      w_p;
  logic [11:0]      s_p;
  logic [11:0]      d_p;

  // Stage M delay lines, aligned with the multiplier product
  logic [MUL_LAT-1:0] vld_d;
  logic [MUL_LAT-1:0] mode_d;
  logic [TAG_W-1:0]   tag_d [MUL_LAT];
  logic [11:0]        u_d   [MUL_LAT];
  logic [11:0]        s_d   [MUL_LAT];

  logic [11:0] mul_a;
  logic [11:0] prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared along with the valid bits so the outputs read
      // a deterministic 0 after reset instead of leftover pipeline contents.
      valid_p <= 1'b0;
      mode_p  <= 1'b0;
      tag_p   <= '0;
      u_p     <= '0;
      v_p     <= '0;
      w_p     <= '0;
      s_p     <= '0;
      d_p     <= '0;
    end else begin
      valid_p <= in_valid;
      mode_p  <= mode;
      tag_p   <= tag;
      u_p     <= u;
      v_p     <= v;
      w_p     <= w;
      s_p     <= modadd(u, v);
      d_p     <= modsub(u, v);
    end
  end

  assign mul_a = mode_p ? d_p : v_p;

  modular_mul #(.Q(Q)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (w_p),
    .p   (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_d  <= '0;
      mode_d <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_d[i] <= '0;
        u_d[i]   <= '0;
        s_d[i]   <= '0;
      end
    end else begin
      vld_d[0]  <= valid_p;
      mode_d[0] <= mode_p;
      tag_d[0]  <= tag_p;
      u_d[0]    <= u_p;
      s_d[0]    <= s_p;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_d[i]  <= vld_d[i-1];
        mode_d[i] <= mode_d[i-1];
        tag_d[i]  <= tag_d[i-1];
        u_d[i]    <= u_d[i-1];
        s_d[i]    <= s_d[i-1];
      end
    end
  end

  // Stage O
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= vld_d[MUL_LAT-1];
      out_tag   <= tag_d[MUL_LAT-1];
      if (mode_d[MUL_LAT-1]) begin
        out0 <= s_d[MUL_LAT-1];
        out1 <= prod;
      end else begin
        out0 <= modadd(u_d[MUL_LAT-1], prod);
        out1 <= modsub(u_d[MUL_LAT-1], prod);
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Scoreboard bench for ntt_butterfly: the driver pushes model results with their due cycle,
// and an independent monitor pops and compares whenever out_valid is seen.

module tb_ntt_butterfly;

  localparam int Q     = 3329;
  localparam int LAT   = 5;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             mode;
  logic [11:0]      u;
  logic [11:0]      v;
  logic [11:0]      w;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic [11:0]      out0;
  logic [11:0]      out1;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    int unsigned due;
    int          o0;
    int          o1;
    int          tg;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc      = 0;
  int          checks   = 0;
  int          failures = 0;

  ntt_butterfly #(.Q(Q), .MUL_LAT(3), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mode      (mode),
    .u         (u),
    .v         (v),
    .w         (w),
    .tag       (tag),
    .out_valid (out_valid),
    .out0      (out0),
    .out1      (out1),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results straight from the butterfly equations, using plain integer arithmetic
  function automatic exp_t model(input bit md, input int uu, input int vv, input int ww,
                                 input int tt, input int unsigned due);
    exp_t e;
    int   wv;
    int   diff;
    e.due = due;
    e.tg  = tt;
    if (!md) begin
      wv   = (ww * vv) % Q;
      e.o0 = (uu + wv) % Q;
      e.o1 = (uu - wv + Q) % Q;
    end else begin
      diff = (uu - vv + Q) % Q;
      e.o0 = (uu + vv) % Q;
      e.o1 = (diff * ww) % Q;
    end
    return e;
  endfunction

  task automatic beat(input bit md, input int uu, input int vv, input int ww, input int tt);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    mode     = md;
    u        = 12'(uu);
    v        = 12'(vv);
    w        = 12'(ww);
    tag      = TAG_W'(tt);
    sb.push_back(model(md, uu, vv, ww, tt, cyc + LAT));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b0;
    u        = '0;
    v        = '0;
    w        = '0;
    tag      = '0;
  endtask

  task automatic randomize_data();
    mode = 1'($urandom_range(0, 1));
    u    = 12'($urandom_range(0, Q - 1));
    v    = 12'($urandom_range(0, Q - 1));
    w    = 12'($urandom_range(0, Q - 1));
    tag  = TAG_W'($urandom);
  endtask

  task automatic check_zero_outputs(input string phase);
    @(negedge clk);
    check({phase, "_out_valid"}, 32'(out_valid), 0);
    check({phase, "_out0"},      32'(out0),      0);
    check({phase, "_out1"},      32'(out1),      0);
    check({phase, "_out_tag"},   32'(out_tag),   0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every out_valid must match the oldest outstanding beat, on its due cycle
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", cyc, mon_e.due);
        check("out0",    32'(out0),    32'(mon_e.o0));
        check("out1",    32'(out1),    32'(mon_e.o1));
        check("out_tag", 32'(out_tag), 32'(mon_e.tg));
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      check("missing_valid", 0, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    int beats;
    int k;

    // Reset held for 3 cycles with in_valid asserted; nothing may come out
    rst      = 1'b1;
    in_valid = 1'b1;
    randomize_data();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        rst      = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        u        = '0;
        v        = '0;
        w        = '0;
        tag      = '0;
      end else begin
        randomize_data();
      end
      check_zero_outputs("reset");
    end
    for (int i = 0; i < LAT; i++) begin
      idle();
      check_zero_outputs("post_reset");
    end

    // Directed Cooley-Tukey and Gentleman-Sande beats
    beat(1'b0, 100, 200, 17, 8'h11);
    for (int i = 0; i < LAT + 1; i++) idle();
    beat(1'b0, 10, 1, 3328, 8'h21);
    beat(1'b0, 0, 0, 0, 8'h22);
    beat(1'b1, 3000, 500, 2, 8'h31);
    beat(1'b1, 5, 10, 1, 8'h32);
    beat(1'b1, 3328, 3328, 3328, 8'h33);
    beat(1'b0, 3328, 3328, 3328, 8'h34);
    drain();

    // Streaming: alternating modes with a bubble every 7th cycle
    beats = 0;
    k     = 0;
    while (beats < 32) begin
      if (k % 7 == 6) begin
        idle();
      end else begin
        beat(1'(beats % 2), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
             $urandom_range(0, Q - 1), beats);
        beats++;
      end
      k++;
    end
    drain();

    // Mid-stream reset with 4 beats in flight; a beat during reset is also dropped
    for (int i = 0; i < 4; i++) begin
      beat(1'(i % 2), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
           $urandom_range(0, Q - 1), 8'h40 + i);
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    randomize_data();
    sb.delete();
    beat(1'b1, 1234, 2345, 77, 8'h5A);
    drain();

    for (int i = 0; i < 3; i++) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
